// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped L1 instruction cache.
// The default geometry here matches the icache_l1 parameter defaults.
package icache_pkg;

    localparam int DEF_LINES  = 16;
    localparam int DEF_WORDS  = 4;
    localparam int DEF_ADDR_W = 32;

    localparam int INDEX_W  = $clog2(DEF_LINES);
    localparam int OFFSET_W = $clog2(DEF_WORDS);
    localparam int TAG_W    = DEF_ADDR_W - INDEX_W - OFFSET_W - 2;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for icache_l1: asynchronous read, one word write per
// cycle, tag+valid set at line completion and a single-cycle bulk invalidate.
module icache_array #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 26
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [$clog2(LINES)-1:0]          rd_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_offset,
    output logic [31:0]                       rd_data,
    output logic [TAG_W-1:0]                  rd_tag,
    output logic                              rd_valid,
    input  logic                              wr_en,
    input  logic [$clog2(LINES)-1:0]          wr_index,
    input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_offset,
    input  logic [31:0]                       wr_data,
    input  logic                              set_en,
    input  logic [TAG_W-1:0]                  set_tag,
    input  logic                              set_valid,
    input  logic                              inval_all
);

    logic [31:0]      data_mem [LINES*WORDS_PER_LINE];
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [LINES-1:0] valid_q;

    assign rd_data  = data_mem[{rd_index, rd_offset}];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid_q[rd_index];

    // Contents are only trusted behind a valid bit, so the arrays carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[{wr_index, wr_offset}] <= wr_data;
        end
        if (set_en) begin
            tag_mem[wr_index] <= set_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (inval_all) begin
            valid_q <= '0;
        end else if (set_en && set_valid) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

endmodule

// File: rtl/icache_l1.sv
// Direct-mapped read-only L1 instruction cache: combinational hit path, stall
// and single-line refill on miss. Optional hit/miss counters via ICACHE_STATS_EN.
//
// state | meaning
// IDLE  | lookup held pc; hit returns instr, miss latches line address
// REQ   | refill request presented until memory accepts it
// FILL  | collecting response beats in ascending word order
module icache_l1
    import icache_pkg::*;
#(
    parameter int LINES          = DEF_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic              stall,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int IDX_W    = $clog2(LINES);
    localparam int OFF_W    = $clog2(WORDS_PER_LINE);
    localparam int TG_W     = ADDR_W - IDX_W - OFF_W - 2;
    localparam int LINE_LSB = OFF_W + 2;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    state_t                     state_q, state_d;
    logic [ADDR_W-LINE_LSB-1:0] line_q;
    logic [OFF_W-1:0]           cnt_q;
    logic                       flush_pend_q;

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx;
    logic [TG_W-1:0]  pc_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TG_W-1:0]  fill_tag;
    logic [31:0]      rd_data;
    logic [TG_W-1:0]  rd_tag;
    logic             rd_valid;
    logic             hit;
    logic             wr_en, set_en, latch_line, idle_hit;
    logic             unused_pc;

    assign pc_off    = pc[LINE_LSB-1:2];
    assign pc_idx    = pc[LINE_LSB +: IDX_W];
    assign pc_tag    = pc[ADDR_W-1 -: TG_W];
    assign unused_pc = ^pc[1:0];

    assign fill_idx = line_q[IDX_W-1:0];
    assign fill_tag = line_q[IDX_W +: TG_W];

    assign hit          = rd_valid && (rd_tag == pc_tag);
    assign mem_req_addr = {line_q, {LINE_LSB{1'b0}}};

    icache_array #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (pc_idx),
        .rd_offset (pc_off),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .rd_valid  (rd_valid),
        .wr_en     (wr_en),
        .wr_index  (fill_idx),
        .wr_offset (cnt_q),
        .wr_data   (mem_rsp_data),
        .set_en    (set_en),
        .set_tag   (fill_tag),
        .set_valid (!(flush_pend_q || flush)),
        .inval_all (flush)
    );

    always_comb begin
        state_d       = state_q;
        stall         = 1'b1;
        instr         = NOP_INSTR;
        mem_req_valid = 1'b0;
        wr_en         = 1'b0;
        set_en        = 1'b0;
        latch_line    = 1'b0;
        idle_hit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    stall    = 1'b0;
                    instr    = rd_data;
                    idle_hit = 1'b1;
                end else begin
                    latch_line = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (mem_rsp_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == LAST_WORD) begin
                        set_en  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            line_q       <= '0;
            cnt_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_line) begin
                line_q <= pc[ADDR_W-1:LINE_LSB];
            end
            if (state_q == REQ) begin
                cnt_q <= '0;
            end else if (wr_en) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // A flush seen mid-refill keeps the arriving line from being marked valid.
            if (set_en) begin
                flush_pend_q <= 1'b0;
            end else if (flush && (state_q != IDLE)) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (idle_hit) begin
                hit_q <= hit_q + 32'd1;
            end
            if (latch_line) begin
                miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    logic unused_stats;
    assign unused_stats = idle_hit;
    assign hit_count    = '0;
    assign miss_count   = '0;
`endif

endmodule

// File: tb/tb_icache_l1.sv
// Randomized self-checking bench for icache_l1 against a line-residency model.
module tb_icache_l1;
    import icache_pkg::*;

    localparam int NLINES     = 1 << INDEX_W;
    localparam int NWORDS     = 1 << OFFSET_W;
    localparam int LINE_SHIFT = OFFSET_W + 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = '0;
    logic [31:0] instr;
    logic        stall;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int passes = 0;

    bit          mvalid [NLINES];
    logic [31:0] mline  [NLINES];
    int          hits_m = 0;
    int          misses_m = 0;

    icache_l1 dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .instr         (instr),
        .stall         (stall),
        .flush         (flush),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .hit_count     (hit_count),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'h3;
        if ((w >> 4) == 32'h10) return 32'hA0 + ((w >> 2) & 32'h3);
        return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int idx;
        idx = int'((a >> LINE_SHIFT) % NLINES);
        return mvalid[idx] && (mline[idx] == (a >> LINE_SHIFT));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NLINES; i++) mvalid[i] = 1'b0;
    endtask

    task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
        check({tag, "_hits"}, hit_count, hits_m);
        check({tag, "_misses"}, miss_count, misses_m);
`else
        check({tag, "_hits"}, hit_count, 32'd0);
        check({tag, "_misses"}, miss_count, 32'd0);
`endif
    endtask

    // Called at posedge+1; returns at posedge+1. Retries the lookup until it hits.
    task automatic fetch(input logic [31:0] a, input int rdy_wait, input int max_gap,
                         input int flush_beat, input int rst_beat, input bit hit_flush);
        logic [31:0] line;
        int fb, g, attempts;
        bit fl;
        line = a & ~32'(NWORDS * 4 - 1);
        fb = flush_beat;
        attempts = 0;
        while (attempts < 4) begin
            pc = a;
            if (model_hit(a)) flush = hit_flush;
            @(negedge clk);
            if (model_hit(a)) begin
                check("hit_stall", stall, 1'b0);
                check("hit_instr", instr, mem_word(a));
                hits_m++;
                @(posedge clk); #1;
                if (flush) model_clear();
                flush = 1'b0;
                return;
            end
            check("miss_stall", stall, 1'b1);
            check("miss_instr", instr, NOP);
            check("miss_idle_req", mem_req_valid, 1'b0);
            misses_m++;
            fl = 1'b0;
            @(posedge clk); #1;
            for (int i = 0; i < rdy_wait; i++) begin
                mem_req_ready = 1'b0;
                pc = $urandom;
                @(negedge clk);
                check("bp_req_valid", mem_req_valid, 1'b1);
                check("bp_req_addr", mem_req_addr, line);
                check("bp_stall", stall, 1'b1);
                @(posedge clk); #1;
            end
            pc = a;
            mem_req_ready = 1'b1;
            @(negedge clk);
            check("req_valid", mem_req_valid, 1'b1);
            check("req_addr", mem_req_addr, line);
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            for (int b = 0; b < NWORDS; b++) begin
                g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                repeat (g) begin
                    @(negedge clk);
                    check("gap_stall", stall, 1'b1);
                    check("gap_req_valid", mem_req_valid, 1'b0);
                    @(posedge clk); #1;
                end
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_word(line + 32'(b * 4));
                if (b == rst_beat) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check("rst_req_valid", mem_req_valid, 1'b0);
                    check("rst_stall", stall, 1'b1);
                    check("rst_instr", instr, NOP);
                    model_clear();
                    hits_m = 0;
                    misses_m = 0;
                    repeat (2) @(posedge clk);
                    #1;
                    rst = 1'b0;
                    mem_rsp_valid = 1'b0;
                    return;
                end
                if (b == fb) begin
                    flush = 1'b1;
                    fl = 1'b1;
                end
                @(negedge clk);
                check("fill_stall", stall, 1'b1);
                @(posedge clk); #1;
                if (flush) model_clear();
                flush = 1'b0;
                mem_rsp_valid = 1'b0;
                mem_rsp_data = $urandom;
            end
            if (!fl) begin
                mvalid[int'((a >> LINE_SHIFT) % NLINES)] = 1'b1;
                mline[int'((a >> LINE_SHIFT) % NLINES)] = a >> LINE_SHIFT;
            end
            fb = -1;
            attempts++;
        end
        check("fetch_retry_budget", attempts, 32'd3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, tag;
        model_clear();
        @(negedge clk);
        check("rst_stall", stall, 1'b1);
        check("rst_instr", instr, NOP);
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        check_stats("rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold miss, then same-line hits (1 miss, 5 hit cycles)
        fetch(32'h100, 0, 0, -1, -1, 1'b0);
        fetch(32'h10C, 0, 0, -1, -1, 1'b0);
        fetch(32'h104, 0, 0, -1, -1, 1'b0);
        fetch(32'h108, 0, 0, -1, -1, 1'b0);
        fetch(32'h100, 0, 0, -1, -1, 1'b0);
        check_stats("stats");

        // Conflict eviction on index 0
        fetch(32'h200, 0, 0, -1, -1, 1'b0);
        fetch(32'h100, 0, 0, -1, -1, 1'b0);

        // Backpressure and gapped beats
        fetch(32'h340, 3, 2, -1, -1, 1'b0);

        // Flush mid-fill forces a second refill of the same line
        fetch(32'h480, 0, 1, 1, -1, 1'b0);

        // Flush on an IDLE hit: that hit stands, next lookup misses
        fetch(32'h484, 0, 0, -1, -1, 1'b1);
        fetch(32'h488, 0, 0, -1, -1, 1'b0);

        // Reset during beat 2, then 0x100 misses again
        fetch(32'h500, 0, 0, -1, 2, 1'b0);
        check_stats("after_rst");
        fetch(32'h100, 0, 0, -1, -1, 1'b0);

        for (int n = 0; n < 200; n++) begin
            tag = ($urandom_range(7, 0) == 0) ? ($urandom & 32'((64'd1 << TAG_W) - 1))
                                              : 32'($urandom_range(3, 0));
            a = (tag << (INDEX_W + LINE_SHIFT))
              | (32'($urandom_range(NLINES - 1, 0)) << LINE_SHIFT)
              | (32'($urandom_range(NWORDS - 1, 0)) << 2)
              | 32'($urandom_range(3, 0));
            fetch(a, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)),
                  ($urandom_range(7, 0) == 0) ? int'($urandom_range(NWORDS - 1, 0)) : -1,
                  -1, ($urandom_range(9, 0) == 0));
        end
        check_stats("final");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
